// File: rtl/serial_mem_adapter.sv
// serial_mem_adapter: bridges a 32-bit host serial word stream to a 64-bit-addressed word memory port.
// Revision 1.0 -- initial release.
`default_nettype none

module serial_mem_adapter (
  input  logic        clock,
  input  logic        reset,
  input  logic        serial_in_valid,
  output logic        serial_in_ready,
  input  logic [31:0] serial_in_bits,
  output logic        serial_out_valid,
  input  logic        serial_out_ready,
  output logic [31:0] serial_out_bits,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_write,
  output logic [63:0] mem_req_addr,
  output logic [31:0] mem_req_data,
  input  logic        mem_resp_valid,
  output logic        mem_resp_ready,
  input  logic [31:0] mem_resp_data
);

  typedef enum logic [3:0] {
    S_CMD     = 4'd0,
    S_ADDR_LO = 4'd1,
    S_ADDR_HI = 4'd2,
    S_LEN_LO  = 4'd3,
    S_LEN_HI  = 4'd4,
    S_WDATA   = 4'd5,
    S_REQ     = 4'd6,
    S_RESP    = 4'd7,
    S_RDATA   = 4'd8
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        is_write;
  logic [63:0] addr;
  logic [63:0] len;
  logic [63:0] count;
  logic [31:0] data;
  logic        in_state;
  logic        in_fire;
  logic        cmd_ok;
  logic        last_word;

  assign in_state = (state == S_CMD) || (state == S_ADDR_LO) || (state == S_ADDR_HI) ||
                    (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_WDATA);
  assign serial_in_ready = in_state && !reset;
  assign in_fire   = serial_in_valid && serial_in_ready;
  assign cmd_ok    = (serial_in_bits[31:1] == 31'd0);
  assign last_word = (count == 64'd0);

  always_ff @(posedge clock) begin
    if (reset) state <= S_CMD;
    else       state <= state_next;
  end

  always_comb begin
    state_next       = state;
    serial_out_valid = 1'b0;
    serial_out_bits  = 32'd0;
    mem_req_valid    = 1'b0;
    mem_req_write    = 1'b0;
    mem_req_addr     = 64'd0;
    mem_req_data     = 32'd0;
    mem_resp_ready   = 1'b0;
    case (state)
      S_CMD:     if (in_fire && cmd_ok) state_next = S_ADDR_LO;
      S_ADDR_LO: if (in_fire) state_next = S_ADDR_HI;
      S_ADDR_HI: if (in_fire) state_next = S_LEN_LO;
      S_LEN_LO:  if (in_fire) state_next = S_LEN_HI;
      S_LEN_HI:  if (in_fire) state_next = is_write ? S_WDATA : S_REQ;
      S_WDATA:   if (in_fire) state_next = S_REQ;
      S_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = is_write;
        mem_req_addr  = addr;
        mem_req_data  = is_write ? data : 32'd0;
        if (mem_req_ready) state_next = S_RESP;
      end
      S_RESP: begin
        mem_resp_ready = 1'b1;
        if (mem_resp_valid) begin
          if (!is_write)      state_next = S_RDATA;
          else if (last_word) state_next = S_CMD;
          else                state_next = S_WDATA;
        end
      end
      S_RDATA: begin
        serial_out_valid = 1'b1;
        serial_out_bits  = data;
        if (serial_out_ready) state_next = last_word ? S_CMD : S_REQ;
      end
      default: state_next = S_CMD;
    endcase
  end

  // Counter holds words remaining after the current one, so an all-ones LEN never needs a 65th bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      is_write <= 1'b0;
      addr     <= 64'd0;
      len      <= 64'd0;
      count    <= 64'd0;
      data     <= 32'd0;
    end else begin
      case (state)
        S_CMD:     if (in_fire && cmd_ok) is_write <= serial_in_bits[0];
        S_ADDR_LO: if (in_fire) addr[31:0]  <= serial_in_bits;
        S_ADDR_HI: if (in_fire) addr[63:32] <= serial_in_bits;
        S_LEN_LO:  if (in_fire) len[31:0]   <= serial_in_bits;
        S_LEN_HI: begin
          if (in_fire) begin
            len[63:32] <= serial_in_bits;
            count       <= {serial_in_bits, len[31:0]};
          end
        end
        S_WDATA:   if (in_fire) data <= serial_in_bits;
        S_RESP: begin
          if (mem_resp_valid) begin
            addr <= addr + 64'd4;
            if (!is_write)       data  <= mem_resp_data;
            else if (!last_word) count <= count - 64'd1;
          end
        end
        S_RDATA: if (serial_out_ready && !last_word) count <= count - 64'd1;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
